// File: rtl/sprite_line_scanner.sv
// Sprite line scanner: walks OAM once per scanline and collects up to
// MAX_PER_LINE sprites whose vertical span covers the target line.
// The OAM read is pipelined, so one entry is evaluated per clock.
// Slots are filled in ascending OAM index order. A sprite that finds
// all slots taken raises overflow and ends the scan.
module sprite_line_scanner #(
  parameter int OAM_ENTRIES  = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_H     = 16,
  localparam int AW = $clog2(OAM_ENTRIES),
  localparam int RW = $clog2(SPRITE_H),
  localparam int CW = $clog2(MAX_PER_LINE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [9:0]                 line,
  output logic [AW-1:0]              oam_addr,
  input  logic [31:0]                oam_data,
  output logic [MAX_PER_LINE-1:0]    slot_valid,
  output logic [MAX_PER_LINE*AW-1:0] slot_idx,
  output logic [MAX_PER_LINE*RW-1:0] slot_row,
  output logic [CW-1:0]              count,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(OAM_ENTRIES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_PER_LINE);
  localparam logic [9:0]    HEIGHT    = 10'(SPRITE_H);

  logic [1:0]                 state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic                       eval_vld_q, eval_vld_d;
  logic [AW-1:0]              eval_idx_q, eval_idx_d;
  logic [9:0]                 line_q, line_d;
  logic [MAX_PER_LINE-1:0]    valid_q, valid_d;
  logic [MAX_PER_LINE*AW-1:0] idx_q, idx_d;
  logic [MAX_PER_LINE*RW-1:0] row_q, row_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [9:0]    diff_s;
  logic          in_range_s;
  logic [RW-1:0] row_s;

  // Vertical hit test on the entry returned by OAM this cycle; the
  // 10-bit subtraction wraps so sprites straddling line 0 still match.
  always_comb begin
    diff_s     = line_q - oam_data[27:18];
    in_range_s = oam_data[31] && (diff_s < HEIGHT);
    if (oam_data[30]) begin
      row_s = ~diff_s[RW-1:0];
    end else begin
      row_s = diff_s[RW-1:0];
    end
  end

  // Next-state logic: address sequencing, slot allocation and FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    eval_vld_d = 1'b0;
    eval_idx_d = eval_idx_q;
    line_d     = line_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    row_d      = row_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (start) begin
      // A start always wins, even mid-scan: restart from entry 0.
      state_d    = ST_SCAN;
      addr_d     = {AW{1'b0}};
      line_d     = line;
      valid_d    = {MAX_PER_LINE{1'b0}};
      idx_d      = {(MAX_PER_LINE*AW){1'b0}};
      row_d      = {(MAX_PER_LINE*RW){1'b0}};
      count_d    = {CW{1'b0}};
      ovf_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SCAN: begin
          eval_vld_d = 1'b1;
          eval_idx_d = addr_q;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_FLUSH;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        ST_FLUSH: begin
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // Evaluate the entry whose address was issued last cycle.
      if (eval_vld_q && in_range_s) begin
        if (count_q == FULL_CNT) begin
          // No free slot: flag overflow and stop looking at entries.
          ovf_d      = 1'b1;
          eval_vld_d = 1'b0;
          if (state_q == ST_SCAN) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          count_d = count_q + CW'(1);
          for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (count_q == CW'(i)) begin
              valid_d[i]          = 1'b1;
              idx_d[i*AW +: AW]   = eval_idx_q;
              row_d[i*RW +: RW]   = row_s;
            end else begin
              valid_d[i] = valid_d[i];
            end
          end
        end
      end else begin
        count_d = count_d;
      end
    end

    busy_d = (state_d == ST_SCAN) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= {AW{1'b0}};
      eval_vld_q <= 1'b0;
      eval_idx_q <= {AW{1'b0}};
      line_q     <= 10'd0;
      valid_q    <= {MAX_PER_LINE{1'b0}};
      idx_q      <= {(MAX_PER_LINE*AW){1'b0}};
      row_q      <= {(MAX_PER_LINE*RW){1'b0}};
      count_q    <= {CW{1'b0}};
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      eval_vld_q <= eval_vld_d;
      eval_idx_q <= eval_idx_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      row_q      <= row_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign oam_addr   = addr_q;
  assign slot_valid = valid_q;
  assign slot_idx   = idx_q;
  assign slot_row   = row_q;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule
